// File: rtl/matvec_load_ctrl.sv
// Loader/sequencer for the matrix-vector multiplier: fetches A (row-major) then B over
// Avalon-MM single reads, hands the operands to the multiplier and captures its sum.
module matvec_load_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_WIDTH-1:0] a_matrix [0:DEPTH-1][0:DEPTH-1],
  output logic [DATA_WIDTH-1:0] b_vector [0:DEPTH-1],
  output logic                  mult_valid,
  input  logic                  done,
  input  logic [23:0]           sum,
  output logic                  busy,
  output logic [23:0]           result,
  output logic                  result_valid,
  output logic                  error
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_REQ     | read request on the bus, held while waitrequest
  // S_WAIT_RD | one read outstanding, waiting for readdatavalid
  // S_MULT    | all operands loaded, raise mult_valid
  // S_WAIT_DONE | multiplier running, waiting for done
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_RD   = 3'd2;
  localparam logic [2:0] S_MULT      = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  localparam int N_ELEM = DEPTH * DEPTH + DEPTH;
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [2:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [TMR_W-1:0]      tmr;
  logic                  wr_en;
  logic                  rdata_unused;

  // Request and address decode straight from state so a reset drops them at once.
  assign avm_read     = (state == S_REQ);
  assign avm_address  = avm_read ? base_q + ADDR_WIDTH'(idx) : '0;
  assign busy         = (state != S_IDLE);
  assign wr_en        = (state == S_WAIT_RD) && avm_readdatavalid;
  assign rdata_unused = ^avm_readdata[31:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      base_q       <= '0;
      tmr          <= '0;
      mult_valid   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            idx    <= '0;
            error  <= 1'b0;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (!avm_waitrequest) begin
            tmr   <= TMR_LOAD;
            state <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          if (avm_readdatavalid) begin
            if (idx == IDX_LAST) begin
              state <= S_MULT;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_REQ;
            end
          end else if (tmr == '0) begin
            error <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_MULT: begin
          mult_valid <= 1'b1;
          tmr        <= TMR_LOAD;
          state      <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // done is checked first so it wins over a coincident timeout
          if (done) begin
            result       <= sum;
            result_valid <= 1'b1;
            mult_valid   <= 1'b0;
            state        <= S_IDLE;
          end else if (tmr == '0) begin
            error      <= 1'b1;
            mult_valid <= 1'b0;
            state      <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < DEPTH; c++) a_matrix[r][c] <= '0;
        b_vector[r] <= '0;
      end
    end else if (wr_en) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          if (idx == IDX_W'(r * DEPTH + c)) a_matrix[r][c] <= avm_readdata[DATA_WIDTH-1:0];
        end
        if (idx == IDX_W'(DEPTH * DEPTH + r)) b_vector[r] <= avm_readdata[DATA_WIDTH-1:0];
      end
    end
  end

endmodule
